// File: rtl/keypad_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scan: 4x4 keypad scanner, debounce, key strobe, 16-bit digit shifter.
// Optional auto-repeat with KEYPAD_AUTOREPEAT_EN.          Revision: 1.0
// ---------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digit
);

  localparam int c_cnt_max = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [c_cnt_w-1:0] c_rep_last = c_cnt_w'(REPEAT_SCANS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [3:0]            r_row_s1;
  logic [3:0]            r_row_s2;
  logic [SCAN_DIV_W-1:0] r_div;
  logic [1:0]            r_col;
  logic [3:0]            r_col_out;
  logic                  r_found;
  logic [3:0]            r_best;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [3:0]            r_cand;
  logic [3:0]            r_code;
  logic                  r_valid;
  logic                  r_held;
  logic [15:0]           r_digit;

  logic                  w_tick;
  logic                  w_scan_done;
  logic                  w_col_hit;
  logic [1:0]            w_col_row;
  logic [3:0]            w_col_code;
  logic                  w_prev_found;
  logic                  w_res_found;
  logic [3:0]            w_res_code;
  logic                  w_accept;

  assign w_tick       = &r_div;
  assign w_scan_done  = w_tick && (r_col == 2'd3);
  assign w_col_hit    = ~&r_row_s2;
  assign w_col_code   = {w_col_row, r_col};
  // The running best is discarded at column 0 so each scan starts fresh.
  assign w_prev_found = r_found && (r_col != 2'd0);

  always_comb begin
    w_col_row = 2'd3;
    if (!r_row_s2[0])      w_col_row = 2'd0;
    else if (!r_row_s2[1]) w_col_row = 2'd1;
    else if (!r_row_s2[2]) w_col_row = 2'd2;
  end

  always_comb begin
    w_res_found = w_prev_found;
    w_res_code  = r_best;
    if (w_col_hit && (!w_prev_found || (w_col_code < r_best))) begin
      w_res_found = 1'b1;
      w_res_code  = w_col_code;
    end
  end

  always_comb begin
    w_accept = 1'b0;
    if (w_scan_done && w_res_found) begin
      if ((r_state == S_DEBOUNCE) && (w_res_code == r_cand) && (r_cnt == c_deb_last))
        w_accept = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
      if ((r_state == S_PRESSED) && (r_cnt == c_rep_last))
        w_accept = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_div     <= '0;
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
      r_found   <= 1'b0;
      r_best    <= 4'd0;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
      r_div    <= r_div + SCAN_DIV_W'(1);
      if (w_tick) begin
        r_col     <= r_col + 2'd1;
        r_col_out <= {r_col_out[2:0], r_col_out[3]};
        r_found   <= w_res_found;
        r_best    <= w_res_code;
      end
    end
  end

  // In PRESSED the counter doubles as the auto-repeat interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_digit <= 16'd0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_code  <= r_cand;
        r_digit <= {r_digit[11:0], r_cand};
      end
      if (clear) r_digit <= 16'd0;
      if (w_scan_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_res_found) begin
              r_cand  <= w_res_code;
              r_cnt   <= c_cnt_w'(1);
              r_state <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (w_res_found && (w_res_code == r_cand)) begin
              if (r_cnt == c_deb_last) begin
                r_state <= S_PRESSED;
                r_held  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (!w_res_found) begin
              r_cnt   <= c_cnt_w'(1);
              r_state <= S_RELEASE;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (r_cnt == c_rep_last) r_cnt <= '0;
            else                          r_cnt <= r_cnt + c_cnt_w'(1);
`endif
          end
          S_RELEASE: begin
            if (w_res_found) begin
              r_state <= S_PRESSED;
              r_cnt   <= '0;
            end else if (r_cnt == c_deb_last) begin
              r_state <= S_IDLE;
              r_held  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign digit     = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// tb_keypad_scan: directed per-scan vector table, reset and auto-repeat
// sequences, then random key patterns against a scan-level reference model.
module tb_keypad_scan;

  localparam int W = 2;
  localparam int D = 3;
  localparam int R = 2;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit c_rep_en = 1'b1;
`else
  localparam bit c_rep_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digit;
  logic [15:0] keys = 16'd0;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int doubles = 0;
  logic prev_valid = 1'b0;

  keypad_scan #(.SCAN_DIV_W(W), .DEBOUNCE_SCANS(D), .REPEAT_SCANS(R)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .clear(clear),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .digit(digit)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) strobes++;
    if (key_valid === 1'b1 && prev_valid) doubles++;
    prev_valid = (key_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    keys  = 16'd0;
    clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Must be entered between the last edge of a scan and the first of the next.
  task automatic scan_step(input logic [15:0] m, input logic clr);
    keys = m;
    repeat (15) @(posedge clk);
    #1 clear = clr;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] keys;
    logic        clr;
    logic        v;
    logic [3:0]  code;
    logic        held;
    logic [15:0] dig;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rst, input logic [15:0] k, input logic clr,
                              input logic v, input logic [3:0] code, input logic held,
                              input logic [15:0] dig);
    vec_t e;
    e.rst = rst; e.keys = k; e.clr = clr; e.v = v; e.code = code; e.held = held; e.dig = dig;
    tbl.push_back(e);
  endfunction

  // Reference model: one call per completed scan, driven by the key set seen.
  bit          m_held;
  int          m_run, m_quiet, m_rep;
  logic [3:0]  m_cand, m_code;
  logic [15:0] m_dig;
  logic        m_valid;
  int          m_strobes;

  function automatic int lowest_key(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic void m_accept();
    m_valid = 1'b1;
    m_code  = m_cand;
    m_dig   = {m_dig[11:0], m_cand};
    m_strobes++;
  endfunction

  function automatic void model_scan(input logic [15:0] m, input logic clr);
    int res;
    res = lowest_key(m);
    m_valid = 1'b0;
    if (!m_held) begin
      if (res < 0) m_run = 0;
      else if (m_run == 0) begin m_cand = 4'(res); m_run = 1; end
      else if (res == int'(m_cand)) begin
        m_run++;
        if (m_run == D) begin m_accept(); m_held = 1; m_run = 0; m_quiet = 0; m_rep = 0; end
      end else m_run = 0;
    end else begin
      if (res < 0) begin
        m_quiet++;
        if (m_quiet == D) begin m_held = 0; m_quiet = 0; end
      end else if (m_quiet > 0) begin
        m_quiet = 0;
        m_rep = 0;
      end else if (c_rep_en) begin
        m_rep++;
        if (m_rep == R) begin m_accept(); m_rep = 0; end
      end
    end
    if (clr) m_dig = 16'd0;
  endfunction

  initial begin
    logic [15:0] t2d, dg, dn, mask;
    logic [3:0]  pc;
    int s0, rr;

    // T2: key 6 held six scans, then released
    t2d = c_rep_en ? 16'h0066 : 16'h0006;
    add(1, 16'h0040, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0040, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0040, 0, 1, 6, 1, 16'h0006);
    add(0, 16'h0040, 0, 0, 6, 1, 16'h0006);
    add(0, 16'h0040, 0, c_rep_en, 6, 1, t2d);
    add(0, 16'h0040, 0, 0, 6, 1, t2d);
    add(0, 16'h0000, 0, 0, 6, 1, t2d);
    add(0, 16'h0000, 0, 0, 6, 1, t2d);
    add(0, 16'h0000, 0, 0, 6, 0, t2d);
    // T3: bounce on key A never reaches three consecutive scans
    add(1, 16'h0400, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0400, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0400, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0400, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0);
    // T4: keys 1..5, each fully debounced press and release
    dg = 16'h0; pc = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      mask = 16'h0001 << k;
      dn   = {dg[11:0], 4'(k)};
      add(0, mask, 0, 0, pc, 0, dg);
      add(0, mask, 0, 0, pc, 0, dg);
      add(0, mask, 0, 1, 4'(k), 1, dn);
      add(0, 16'h0, 0, 0, 4'(k), 1, dn);
      add(0, 16'h0, 0, 0, 4'(k), 1, dn);
      add(0, 16'h0, 0, 0, 4'(k), 0, dn);
      dg = dn; pc = 4'(k);
    end
    // T5: keys 5 and 10 together, clear coinciding with the accept
    add(1, 16'h0420, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0420, 0, 0, 0, 0, 16'h0);
    add(0, 16'h0420, 1, 1, 5, 1, 16'h0);
    add(0, 16'h0000, 0, 0, 5, 1, 16'h0);
    add(0, 16'h0000, 0, 0, 5, 1, 16'h0);
    add(0, 16'h0000, 0, 0, 5, 0, 16'h0);

    do_reset();
    check("reset col_out", col_out, 4'b1110);
    check("reset key_code", key_code, 4'h0);
    check("reset key_valid", key_valid, 1'b0);
    check("reset key_held", key_held, 1'b0);
    check("reset digit", digit, 16'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      scan_step(tbl[i].keys, tbl[i].clr);
      check($sformatf("vec%0d key_valid", i), key_valid, tbl[i].v);
      check($sformatf("vec%0d key_code", i), key_code, tbl[i].code);
      check($sformatf("vec%0d key_held", i), key_held, tbl[i].held);
      check($sformatf("vec%0d digit", i), digit, tbl[i].dig);
    end

    // T1: asynchronous reset in the middle of a scan with a key down
    do_reset();
    repeat (3) scan_step(16'h0400, 1'b0);
    check("t1 pre key_held", key_held, 1'b1);
    check("t1 pre key_code", key_code, 4'hA);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t1 async col_out", col_out, 4'b1110);
    check("t1 async key_code", key_code, 4'h0);
    check("t1 async key_valid", key_valid, 1'b0);
    check("t1 async key_held", key_held, 1'b0);
    check("t1 async digit", digit, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t1 restart col_out", col_out, 4'b1110);
    repeat (4) @(posedge clk);
    #1 check("t1 col1 col_out", col_out, 4'b1101);

    // T6: key 9 held for eleven scans
    do_reset();
    s0 = strobes;
    repeat (11) scan_step(16'h0200, 1'b0);
    scan_step(16'h0000, 1'b0);
    check("t6 strobes", strobes - s0, c_rep_en ? 5 : 1);
    check("t6 key_code", key_code, 4'h9);
    check("t6 digit", digit, c_rep_en ? 16'h9999 : 16'h0009);

    // Random key patterns against the reference model
    do_reset();
    m_held = 0; m_run = 0; m_quiet = 0; m_rep = 0;
    m_cand = 4'h0; m_code = 4'h0; m_dig = 16'h0; m_valid = 1'b0; m_strobes = 0;
    s0 = strobes;
    mask = 16'h0;
    for (int n = 0; n < 90; n++) begin
      logic clr;
      rr = $urandom_range(0, 9);
      if (rr < 6)       mask = mask;
      else if (rr < 8)  mask = 16'h0;
      else if (rr == 8) mask = 16'h0001 << $urandom_range(0, 15);
      else              mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      clr = ($urandom_range(0, 9) == 0);
      scan_step(mask, clr);
      model_scan(mask, clr);
      check($sformatf("rnd%0d key_valid", n), key_valid, m_valid);
      check($sformatf("rnd%0d key_code", n), key_code, m_code);
      check($sformatf("rnd%0d key_held", n), key_held, m_held);
      check($sformatf("rnd%0d digit", n), digit, m_dig);
      check($sformatf("rnd%0d col_out", n), col_out, 4'b1110);
    end
    @(negedge clk);
    check("rnd strobe count", strobes - s0, m_strobes);
    check("back-to-back strobes", doubles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
